gcid_dest_mapper: RTL and testbench

- Downstream consumer of the per-dimension local-to-global cell ID conversion: receives particle records tagged with a 3D global cell ID (x, y, z).
- Maps each record to its owning FPGA node and steers it to a local channel (own force pipeline) or a remote channel (inter-FPGA network), each with its own FIFO.
- Frames a cell stream with i_last, drains both FIFOs, then pulses o_done.

---
 rtl/gcid_dest_mapper.sv | 227 ++++++++++++++++++++++
 tb/tb_gcid_dest_mapper.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcid_dest_mapper.sv
// Purpose : map particle records tagged with a 3D global cell ID to their owning node and steer
//           them to a local or remote FWFT FIFO; frame streams with i_last and pulse o_done once drained.
// Latency : 2 cycles from acceptance to o_*_valid (one S1 register stage plus the FIFO write).
// Backpr. : o_ready drops while S1 is blocked by a full target FIFO, and throughout FLUSH/DONE.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   i_valid/o_ready, i_gcid_x/y/z,    input record handshake, global cell coordinates,
//   i_data, i_last                    payload, end-of-stream marker
//   o_lcl_valid/i_lcl_ready/o_lcl_data                local channel (own force pipeline)
//   o_rmt_valid/i_rmt_ready/o_rmt_data/o_rmt_node     remote channel plus destination node
//   o_done                            one-cycle pulse, stream complete and both FIFOs drained
//   o_err                             sticky, an out-of-range coordinate was seen
//   o_lcl_cnt/o_rmt_cnt               per-stream FIFO write counts
//
// Build option: define GCID_DEST_MAPPER_STATS_EN to enable the saturating per-stream counters;
// without it both count ports are tied to zero.

// Generic first-word-fall-through FIFO; DEPTH must be a power of two (>= 2).
// Latency: written entry is visible at dat the cycle after push.
// Backpressure: a push while full is ignored, so callers must gate push with !full.
module gcid_dest_mapper_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    output logic         full,
    input  logic         pop,
    output logic         vld,
    output logic [W-1:0] dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    // Full is based on current occupancy only: a same-cycle pop does not make room.
    assign full    = (count == (AW+1)'(DEPTH));
    assign vld     = (count != '0);
    assign do_push = push && !full;
    assign do_pop  = pop && vld;
    // Payload is forced to zero when empty so idle outputs never show stale entries.
    assign dat     = vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module gcid_dest_mapper #(
    parameter int GCID_W        = 3,
    parameter int GDIM_X        = 4,
    parameter int GDIM_Y        = 4,
    parameter int GDIM_Z        = 4,
    parameter int NCELL_X       = 2,
    parameter int NCELL_Y       = 2,
    parameter int NCELL_Z       = 2,
    parameter int NODE_ID_W     = 3,
    parameter int LOCAL_NODE_ID = 0,
    parameter int DATA_W        = 96,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [GCID_W-1:0]    i_gcid_x,
    input  logic [GCID_W-1:0]    i_gcid_y,
    input  logic [GCID_W-1:0]    i_gcid_z,
    input  logic [DATA_W-1:0]    i_data,
    input  logic                 i_last,
    output logic                 o_lcl_valid,
    input  logic                 i_lcl_ready,
    output logic [DATA_W-1:0]    o_lcl_data,
    output logic                 o_rmt_valid,
    input  logic                 i_rmt_ready,
    output logic [DATA_W-1:0]    o_rmt_data,
    output logic [NODE_ID_W-1:0] o_rmt_node,
    output logic                 o_done,
    output logic                 o_err,
    output logic [15:0]          o_lcl_cnt,
    output logic [15:0]          o_rmt_cnt
);
    localparam int NX = GDIM_X / NCELL_X;
    localparam int NY = GDIM_Y / NCELL_Y;
    localparam int SX = $clog2(NCELL_X);
    localparam int SY = $clog2(NCELL_Y);
    localparam int SZ = $clog2(NCELL_Z);

    typedef enum logic [1:0] {ST_STREAM, ST_FLUSH, ST_DONE} state_t;

    state_t                 state, state_nxt;
    logic                   run_en;
    int                     node_i;
    logic [NODE_ID_W-1:0]   in_node;
    logic                   in_range;
    logic                   accept;

    logic                   s1_valid, s1_local;
    logic [NODE_ID_W-1:0]   s1_node;
    logic [DATA_W-1:0]      s1_data;
    logic                   tgt_full, s1_adv;

    logic                   lcl_push, lcl_full;
    logic                   rmt_push, rmt_full;
    logic [NODE_ID_W+DATA_W-1:0] rmt_head;

    // Node ID of the incoming record; NCELL_* are powers of two so the divide is a shift.
    always_comb begin
        node_i   = int'(i_gcid_x >> SX) + NX * (int'(i_gcid_y >> SY) + NY * int'(i_gcid_z >> SZ));
        in_node  = NODE_ID_W'(node_i);
        in_range = (int'(i_gcid_x) < GDIM_X) && (int'(i_gcid_y) < GDIM_Y) && (int'(i_gcid_z) < GDIM_Z);
    end

    assign tgt_full = s1_local ? lcl_full : rmt_full;
    assign s1_adv   = s1_valid && !tgt_full;
    // run_en keeps o_ready low while rst_n is asserted, so every output reads 0 in reset.
    assign o_ready  = run_en && (state == ST_STREAM) && (!s1_valid || !tgt_full);
    assign accept   = i_valid && o_ready;
    assign lcl_push = s1_adv && s1_local;
    assign rmt_push = s1_adv && !s1_local;
    assign o_done   = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_en   <= 1'b0;
            o_err    <= 1'b0;
            s1_valid <= 1'b0;
            s1_local <= 1'b0;
            s1_node  <= '0;
            s1_data  <= '0;
            state    <= ST_STREAM;
        end else begin
            run_en <= 1'b1;
            state  <= state_nxt;
            if (accept && !in_range) o_err <= 1'b1;
            // Out-of-range records never enter S1; a new record may replace one that advances.
            if (accept && in_range) begin
                s1_valid <= 1'b1;
                s1_local <= (in_node == NODE_ID_W'(LOCAL_NODE_ID));
                s1_node  <= in_node;
                s1_data  <= i_data;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_STREAM: if (accept && i_last) state_nxt = ST_FLUSH;
            ST_FLUSH:  if (!s1_valid && !o_lcl_valid && !o_rmt_valid) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_STREAM;
            default:   state_nxt = ST_STREAM;
        endcase
    end

    gcid_dest_mapper_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_lcl_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (lcl_push),
        .push_dat (s1_data),
        .full     (lcl_full),
        .pop      (i_lcl_ready),
        .vld      (o_lcl_valid),
        .dat      (o_lcl_data)
    );

    gcid_dest_mapper_fifo #(.W(NODE_ID_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_rmt_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (rmt_push),
        .push_dat ({s1_node, s1_data}),
        .full     (rmt_full),
        .pop      (i_rmt_ready),
        .vld      (o_rmt_valid),
        .dat      (rmt_head)
    );

    assign {o_rmt_node, o_rmt_data} = rmt_head;

`ifdef GCID_DEST_MAPPER_STATS_EN
    logic [15:0] lcl_cnt, rmt_cnt;

    // Counts hold through the o_done cycle and clear on the edge that leaves DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcl_cnt <= '0;
            rmt_cnt <= '0;
        end else if (state == ST_DONE) begin
            lcl_cnt <= '0;
            rmt_cnt <= '0;
        end else begin
            if (lcl_push && (lcl_cnt != 16'hFFFF)) lcl_cnt <= lcl_cnt + 16'd1;
            if (rmt_push && (rmt_cnt != 16'hFFFF)) rmt_cnt <= rmt_cnt + 16'd1;
        end
    end

    assign o_lcl_cnt = lcl_cnt;
    assign o_rmt_cnt = rmt_cnt;
`else
    assign o_lcl_cnt = '0;
    assign o_rmt_cnt = '0;
`endif
endmodule

// File: tb/tb_gcid_dest_mapper.sv
module tb_gcid_dest_mapper;
    localparam int GCID_W    = 3;
    localparam int NODE_ID_W = 3;
    localparam int DATA_W    = 96;
    localparam int GDIM      = 4;
    localparam int NCELL     = 2;
    localparam int NPD       = GDIM / NCELL;   // nodes per dimension
    localparam int LOCAL_ID  = 0;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 i_valid = 1'b0;
    logic                 o_ready;
    logic [GCID_W-1:0]    i_gcid_x = '0, i_gcid_y = '0, i_gcid_z = '0;
    logic [DATA_W-1:0]    i_data = '0;
    logic                 i_last = 1'b0;
    logic                 o_lcl_valid, i_lcl_ready = 1'b0;
    logic [DATA_W-1:0]    o_lcl_data;
    logic                 o_rmt_valid, i_rmt_ready = 1'b0;
    logic [DATA_W-1:0]    o_rmt_data;
    logic [NODE_ID_W-1:0] o_rmt_node;
    logic                 o_done, o_err;
    logic [15:0]          o_lcl_cnt, o_rmt_cnt;

    always #5 clk = ~clk;

    gcid_dest_mapper dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_gcid_x(i_gcid_x), .i_gcid_y(i_gcid_y), .i_gcid_z(i_gcid_z),
        .i_data(i_data), .i_last(i_last),
        .o_lcl_valid(o_lcl_valid), .i_lcl_ready(i_lcl_ready), .o_lcl_data(o_lcl_data),
        .o_rmt_valid(o_rmt_valid), .i_rmt_ready(i_rmt_ready), .o_rmt_data(o_rmt_data),
        .o_rmt_node(o_rmt_node), .o_done(o_done), .o_err(o_err),
        .o_lcl_cnt(o_lcl_cnt), .o_rmt_cnt(o_rmt_cnt)
    );

    int total = 0, bad = 0;
    logic [DATA_W-1:0]           lcl_q[$];
    logic [NODE_ID_W+DATA_W-1:0] rmt_q[$];
    int   exp_done = 0, done_seen = 0;
    int   st_lcl = 0, st_rmt = 0;
    logic exp_err = 1'b0;
    int   stalls = 0;
    bit   lcl_hold = 0, rmt_hold = 0, rnd_rdy = 0;
    bit   prev_done = 0, chk_clear = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: ownership from plain integer division of each coordinate.
    function automatic bit in_rng(input int x, input int y, input int z);
        return (x < GDIM) && (y < GDIM) && (z < GDIM);
    endfunction

    function automatic int node_of(input int x, input int y, input int z);
        return (x / NCELL) + NPD * ((y / NCELL) + NPD * (z / NCELL));
    endfunction

    // Ready generator: changes just after the rising edge so values are stable at the falling edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            i_lcl_ready = !lcl_hold && (!rnd_rdy || ($urandom_range(0, 3) != 0));
            i_rmt_ready = !rmt_hold && (!rnd_rdy || ($urandom_range(0, 3) != 0));
        end
    end

    // Monitor / scoreboard: a pop happens at the next rising edge when valid && ready here.
    initial begin
        logic [DATA_W-1:0]           el;
        logic [NODE_ID_W+DATA_W-1:0] er;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (chk_clear) begin
                    chk("lcl_cnt_cleared", 128'(o_lcl_cnt), 128'(0));
                    chk("rmt_cnt_cleared", 128'(o_rmt_cnt), 128'(0));
                    chk_clear = 0;
                end
                if (o_lcl_valid && i_lcl_ready) begin
                    if (lcl_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL lcl_unexpected actual=%0h expected=none", o_lcl_data);
                    end else begin
                        el = lcl_q.pop_front();
                        chk("lcl_data", 128'(o_lcl_data), 128'(el));
                    end
                end
                if (o_rmt_valid && i_rmt_ready) begin
                    if (rmt_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL rmt_unexpected actual=%0h expected=none", o_rmt_data);
                    end else begin
                        er = rmt_q.pop_front();
                        chk("rmt_node_data", 128'({o_rmt_node, o_rmt_data}), 128'(er));
                    end
                end
                if (o_done) begin
                    done_seen++;
                    chk("done_width", 128'(prev_done), 128'(0));
                    chk("err_at_done", 128'(o_err), 128'(exp_err));
`ifdef GCID_DEST_MAPPER_STATS_EN
                    chk("lcl_cnt", 128'(o_lcl_cnt), 128'(st_lcl));
                    chk("rmt_cnt", 128'(o_rmt_cnt), 128'(st_rmt));
`else
                    chk("lcl_cnt", 128'(o_lcl_cnt), 128'(0));
                    chk("rmt_cnt", 128'(o_rmt_cnt), 128'(0));
`endif
                    st_lcl = 0;
                    st_rmt = 0;
                    chk_clear = 1;
                end
                prev_done = o_done;
            end
        end
    end

    task automatic present(input int x, input int y, input int z, input logic last);
        @(negedge clk);
        i_gcid_x = GCID_W'(x);
        i_gcid_y = GCID_W'(y);
        i_gcid_z = GCID_W'(z);
        i_data   = {$urandom(), $urandom(), $urandom()};
        i_last   = last;
        i_valid  = 1'b1;
    endtask

    // Waits for o_ready, records the expected outcome, then lets the accepting edge pass.
    task automatic complete();
        int w = 0;
        int x, y, z, nd;
        #1;
        while (!o_ready && w < 500) begin
            stalls++;
            @(negedge clk);
            #1;
            w++;
        end
        if (!o_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout actual=o_ready_low required=accepted");
            i_valid = 1'b0;
            return;
        end
        x = int'(i_gcid_x); y = int'(i_gcid_y); z = int'(i_gcid_z);
        if (in_rng(x, y, z)) begin
            nd = node_of(x, y, z);
            if (nd == LOCAL_ID) begin
                lcl_q.push_back(i_data);
                st_lcl++;
            end else begin
                rmt_q.push_back({NODE_ID_W'(nd), i_data});
                st_rmt++;
            end
        end else begin
            exp_err = 1'b1;
        end
        if (i_last) exp_done++;
        @(posedge clk);
    endtask

    task automatic send(input int x, input int y, input int z, input logic last);
        present(x, y, z, last);
        complete();
    endtask

    task automatic idle();
        @(negedge clk);
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic wait_done();
        int w = 0;
        while (done_seen != exp_done && w < 300) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        chk("done_count", 128'(done_seen), 128'(exp_done));
        chk("lcl_drained", 128'(lcl_q.size()), 128'(0));
        chk("rmt_drained", 128'(rmt_q.size()), 128'(0));
    endtask

    task automatic send_remote(input logic last);
        int x, y, z;
        do begin
            x = $urandom_range(0, 3); y = $urandom_range(0, 3); z = $urandom_range(0, 3);
        end while (node_of(x, y, z) == LOCAL_ID);
        send(x, y, z, last);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"},     128'(o_ready), 128'(0));
        chk({tag, "_lcl_valid"}, 128'(o_lcl_valid), 128'(0));
        chk({tag, "_rmt_valid"}, 128'(o_rmt_valid), 128'(0));
        chk({tag, "_lcl_data"},  128'(o_lcl_data), 128'(0));
        chk({tag, "_rmt_data"},  128'({o_rmt_node, o_rmt_data}), 128'(0));
        chk({tag, "_done"},      128'(o_done), 128'(0));
        chk({tag, "_err"},       128'(o_err), 128'(0));
        chk({tag, "_cnt"},       128'({o_lcl_cnt, o_rmt_cnt}), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, x, y, z;
        // Reset state
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Local then remote record, with latency check on the local one
        send(1, 1, 1, 1'b0);
        idle();
        chk("lat_not_early", 128'(o_lcl_valid), 128'(0));
        @(negedge clk);
        chk("lat_2cyc", 128'(o_lcl_valid), 128'(1));
        send(2, 0, 0, 1'b1);
        idle();
        wait_done();

        // Remote backpressure: 4 in FIFO + 1 in S1, the sixth must stall
        rmt_hold = 1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) send_remote(1'b0);
        present(3, 3, 3, 1'b1);
        #1 chk("bp_ready_low", 128'(o_ready), 128'(0));
        repeat (3) @(negedge clk);
        #1 chk("bp_ready_still_low", 128'(o_ready), 128'(0));
        chk("bp_rmt_valid", 128'(o_rmt_valid), 128'(1));
        rmt_hold = 0;
        complete();
        idle();
        wait_done();

        // Corner node, out-of-range drop carrying i_last, stats 1/1
        send(0, 0, 0, 1'b0);
        send(3, 3, 3, 1'b0);
        send(4, 0, 0, 1'b1);
        idle();
        chk("err_set", 128'(o_err), 128'(1));
        wait_done();

        // Back-to-back throughput with both consumers always ready
        stalls = 0;
        for (int i = 0; i < 16; i++)
            send($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), i == 15);
        chk("throughput_stalls", 128'(stalls), 128'(0));
        idle();
        wait_done();
        chk("err_sticky", 128'(o_err), 128'(1));

        // Reset while both FIFOs hold data
        lcl_hold = 1; rmt_hold = 1;
        repeat (2) @(negedge clk);
        send(0, 0, 0, 1'b0);
        send(2, 0, 0, 1'b0);
        send(1, 0, 1, 1'b0);
        send(0, 2, 0, 1'b0);
        idle();
        repeat (3) @(negedge clk);
        chk("pre_rst_lcl_valid", 128'(o_lcl_valid), 128'(1));
        chk("pre_rst_rmt_valid", 128'(o_rmt_valid), 128'(1));
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        lcl_q.delete(); rmt_q.delete();
        st_lcl = 0; st_rmt = 0; exp_err = 1'b0; chk_clear = 0; prev_done = 0;
        lcl_hold = 0; rmt_hold = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_done_after_reset", 128'(done_seen), 128'(exp_done));

        // Randomized streams with random consumer readiness and input gaps
        rnd_rdy = 1;
        for (int s = 0; s < 6; s++) begin
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                x = $urandom_range(0, 3); y = $urandom_range(0, 3); z = $urandom_range(0, 3);
                if ($urandom_range(0, 9) == 0) x = $urandom_range(4, 7);
                send(x, y, z, i == len - 1);
                if ($urandom_range(0, 3) == 0) idle();
            end
            idle();
            wait_done();
        end
        chk("err_final", 128'(o_err), 128'(exp_err));

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
